// File: rtl/pc_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack_if
//  Description : Control-word and status bundle between the control-word
//                decoder (master) and the program counter / return stack
//                (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  // Operation requests from the decoder
  logic             count_en;
  logic             jmp_en;
  logic             jcond_en;
  logic             cond_flag;
  logic             call_en;
  logic             ret_en;
  logic             halt;
  logic [WIDTH-1:0] jaddr;

  // Program-counter status back to the control/address path
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp;
  logic             stack_full;
  logic             stack_empty;
  logic             halted;
  logic             err;

  modport master (
    output count_en, jmp_en, jcond_en, cond_flag, call_en, ret_en, halt, jaddr,
    input  pc, sp, stack_full, stack_empty, halted, err
  );

  modport slave (
    input  count_en, jmp_en, jcond_en, cond_flag, call_en, ret_en, halt, jaddr,
    output pc, sp, stack_full, stack_empty, halted, err
  );
endinterface
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack
//  Description : Program counter with increment, absolute and conditional
//                jump, call/return through an internal return-address stack,
//                sticky error flag and a sticky halt state.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  wire logic  CLK,
  input  wire logic  RST,
  pc_stack_if.slave  bus
);

  localparam int SPW   = $clog2(DEPTH + 1);
  // Stack slot index width; storage is rounded up to a power of two so that
  // the index never needs range checking. Only DEPTH slots are ever used.
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDXW;

  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_EMPTY = '0;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [0:SLOTS-1];

  // Stack write port and datapath helpers
  logic             push_en;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  pop_idx;
  logic [WIDTH-1:0] pc_inc;
  logic             full;
  logic             empty;
  logic             run_en;
  logic             halted;

  assign pc_inc   = pc_q + WIDTH'(1);
  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == SP_EMPTY);
  // sp is in 1..DEPTH when popping, so the low bits minus one give the top slot
  assign push_idx = sp_q[IDXW-1:0];
  assign pop_idx  = sp_q[IDXW-1:0] - IDXW'(1);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register: reset always returns to RUN
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt is terminal until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.halt) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs: ops execute only in RUN and only when halt is not requested
  always_comb begin
    halted = 1'b0;
    run_en = 1'b0;
    case (state_q)
      ST_RUN:    run_en = ~bus.halt;
      ST_HALTED: halted = 1'b1;
      default:   run_en = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Select one op per cycle by fixed priority; lower ops are dropped
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (run_en) begin
      if (bus.ret_en) begin
        if (!empty) begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - SPW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.call_en) begin
        if (!full) begin
          push_en = 1'b1;
          pc_d    = bus.jaddr;
          sp_d    = sp_q + SPW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.jmp_en) begin
        pc_d = bus.jaddr;
      end else if (bus.jcond_en && bus.cond_flag) begin
        pc_d = bus.jaddr;
      end else if (bus.count_en) begin
        pc_d = pc_inc;
      end
    end
  end

  // Architectural registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (!RST && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.halted      = halted;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_stack
//  Description : Directed, table-driven bench for pc_stack (WIDTH=4, DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  typedef struct {
    string            name;
    logic             rst;
    logic             cnt;
    logic             jmp;
    logic             jc;
    logic             cf;
    logic             call;
    logic             ret;
    logic             hlt;
    logic [WIDTH-1:0] ja;
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             err;
    logic             halted;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name,
                              input logic r, input logic cnt, input logic jmp,
                              input logic jc, input logic cf, input logic call,
                              input logic ret, input logic hlt,
                              input int ja, input int pc, input int sp,
                              input logic err, input logic halted);
    vec_t v;
    v.name = name; v.rst = r; v.cnt = cnt; v.jmp = jmp; v.jc = jc; v.cf = cf;
    v.call = call; v.ret = ret; v.hlt = hlt;
    v.ja = WIDTH'(ja); v.pc = WIDTH'(pc); v.sp = SPW'(sp);
    v.err = err; v.halted = halted;
    return v;
  endfunction

  // Drive one cycle of inputs, then compare all outputs after the edge
  task automatic step(input vec_t v);
    logic exp_full, exp_empty;
    @(negedge clk);
    rst           = v.rst;
    bus.count_en  = v.cnt;
    bus.jmp_en    = v.jmp;
    bus.jcond_en  = v.jc;
    bus.cond_flag = v.cf;
    bus.call_en   = v.call;
    bus.ret_en    = v.ret;
    bus.halt      = v.hlt;
    bus.jaddr     = v.ja;
    @(posedge clk);
    #1;
    exp_full  = (v.sp == SPW'(DEPTH));
    exp_empty = (v.sp == '0);
    n_tests++;
    if (bus.pc !== v.pc || bus.sp !== v.sp || bus.err !== v.err ||
        bus.halted !== v.halted || bus.stack_full !== exp_full ||
        bus.stack_empty !== exp_empty) begin
      n_fail++;
      $display("FAIL %s (#%0d): got pc=%0d sp=%0d err=%b halted=%b full=%b empty=%b, want pc=%0d sp=%0d err=%b halted=%b full=%b empty=%b",
               v.name, n_tests, bus.pc, bus.sp, bus.err, bus.halted,
               bus.stack_full, bus.stack_empty, v.pc, v.sp, v.err, v.halted,
               exp_full, exp_empty);
    end
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  initial begin
    bus.count_en = 0; bus.jmp_en = 0; bus.jcond_en = 0; bus.cond_flag = 0;
    bus.call_en = 0; bus.ret_en = 0; bus.halt = 0; bus.jaddr = '0;

    //                     name          r cnt jmp jc cf call ret hlt ja pc sp err h
    // Reset and free-running count with wrap
    tbl_a.push_back(mk("reset",        1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0));
    for (int i = 1; i <= 17; i++)
      tbl_a.push_back(mk("count",      0, 1, 0, 0, 0, 0, 0, 0,  0, i % 16, 0, 0, 0));
    // Single call / return
    tbl_a.push_back(mk("cnt_to2",      0, 1, 0, 0, 0, 0, 0, 0,  0,  2, 0, 0, 0));
    tbl_a.push_back(mk("cnt_to3",      0, 1, 0, 0, 0, 0, 0, 0,  0,  3, 0, 0, 0));
    tbl_a.push_back(mk("call9",        0, 0, 0, 0, 0, 1, 0, 0,  9,  9, 1, 0, 0));
    tbl_a.push_back(mk("sub_cnt1",     0, 1, 0, 0, 0, 0, 0, 0,  0, 10, 1, 0, 0));
    tbl_a.push_back(mk("sub_cnt2",     0, 1, 0, 0, 0, 0, 0, 0,  0, 11, 1, 0, 0));
    tbl_a.push_back(mk("ret_to4",      0, 0, 0, 0, 0, 0, 1, 0,  0,  4, 0, 0, 0));
    // Nest to full, overflow, unwind LIFO, underflow
    tbl_a.push_back(mk("nest1",        0, 0, 0, 0, 0, 1, 0, 0,  1,  1, 1, 0, 0));
    tbl_a.push_back(mk("nest2",        0, 0, 0, 0, 0, 1, 0, 0,  2,  2, 2, 0, 0));
    tbl_a.push_back(mk("nest3",        0, 0, 0, 0, 0, 1, 0, 0,  3,  3, 3, 0, 0));
    tbl_a.push_back(mk("nest4_full",   0, 0, 0, 0, 0, 1, 0, 0, 10, 10, 4, 0, 0));
    tbl_a.push_back(mk("call_ovf",     0, 1, 0, 0, 0, 1, 0, 0,  2, 10, 4, 1, 0));
    tbl_a.push_back(mk("unwind1",      0, 0, 0, 0, 0, 0, 1, 0,  0,  4, 3, 1, 0));
    tbl_a.push_back(mk("unwind2",      0, 0, 0, 0, 0, 0, 1, 0,  0,  3, 2, 1, 0));
    tbl_a.push_back(mk("unwind3",      0, 0, 0, 0, 0, 0, 1, 0,  0,  2, 1, 1, 0));
    tbl_a.push_back(mk("unwind4",      0, 0, 0, 0, 0, 0, 1, 0,  0,  5, 0, 1, 0));
    tbl_a.push_back(mk("ret_udf",      0, 1, 0, 0, 0, 0, 1, 0,  0,  5, 0, 1, 0));
    tbl_a.push_back(mk("err_sticky",   0, 1, 0, 0, 0, 0, 0, 0,  0,  6, 0, 1, 0));
    tbl_a.push_back(mk("rst_clr_err",  1, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0));
    // Conditional jump and priority
    tbl_a.push_back(mk("jmp5",         0, 0, 1, 0, 0, 0, 0, 0,  5,  5, 0, 0, 0));
    tbl_a.push_back(mk("jc_nf_cnt",    0, 1, 0, 1, 0, 0, 0, 0,  7,  6, 0, 0, 0));
    tbl_a.push_back(mk("jmp5b",        0, 0, 1, 0, 0, 0, 0, 0,  5,  5, 0, 0, 0));
    tbl_a.push_back(mk("jc_taken",     0, 1, 0, 1, 1, 0, 0, 0,  7,  7, 0, 0, 0));
    tbl_a.push_back(mk("jc_nf_hold",   0, 0, 0, 1, 0, 0, 0, 0, 12,  7, 0, 0, 0));
    tbl_a.push_back(mk("idle_hold",    0, 0, 0, 0, 1, 0, 0, 0, 12,  7, 0, 0, 0));
    tbl_a.push_back(mk("jmp_over_cnt", 0, 1, 1, 1, 0, 0, 0, 0, 12, 12, 0, 0, 0));
    tbl_a.push_back(mk("call8",        0, 0, 0, 0, 0, 1, 0, 0,  8,  8, 1, 0, 0));
    tbl_a.push_back(mk("ret_beats_all",0, 1, 1, 0, 0, 1, 1, 0,  3, 13, 0, 0, 0));
    tbl_a.push_back(mk("call_over_jmp",0, 1, 1, 1, 1, 1, 0, 0,  3,  3, 1, 0, 0));
    tbl_a.push_back(mk("ret_to14",     0, 0, 0, 0, 0, 0, 1, 0,  0, 14, 0, 0, 0));
    tbl_a.push_back(mk("jmp6",         0, 0, 1, 0, 0, 0, 0, 0,  6,  6, 0, 0, 0));

    foreach (tbl_a[i]) step(tbl_a[i]);

    // Halt: pc held on the halt edge, then every input ignored until reset
    step(mk("halt_at6",                0, 1, 0, 0, 0, 0, 0, 1,  0,  6, 0, 0, 1));
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: step(mk("halted_call",      0, 0, 0, 0, 0, 1, 0, 0,  9,  6, 0, 0, 1));
        1: step(mk("halted_jmp",       0, 0, 1, 0, 0, 0, 0, 0,  9,  6, 0, 0, 1));
        2: step(mk("halted_cnt",       0, 1, 0, 1, 1, 0, 0, 1,  9,  6, 0, 0, 1));
        default: step(mk("halted_ret", 0, 0, 0, 0, 0, 0, 1, 0,  9,  6, 0, 0, 1));
      endcase
    end
    step(mk("rst_unhalt",              1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0));

    // Reset beats a call in flight; pc+1 wraps when pushed
    tbl_b.push_back(mk("pre_call3",    0, 0, 0, 0, 0, 1, 0, 0,  3,  3, 1, 0, 0));
    tbl_b.push_back(mk("pre_call7",    0, 0, 0, 0, 0, 1, 0, 0,  7,  7, 2, 0, 0));
    tbl_b.push_back(mk("rst_vs_call",  1, 0, 0, 0, 0, 1, 0, 0,  9,  0, 0, 0, 0));
    tbl_b.push_back(mk("jmp15",        0, 0, 1, 0, 0, 0, 0, 0, 15, 15, 0, 0, 0));
    tbl_b.push_back(mk("call_at15",    0, 0, 0, 0, 0, 1, 0, 0,  2,  2, 1, 0, 0));
    tbl_b.push_back(mk("ret_wrap0",    0, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0));
    tbl_b.push_back(mk("rst_vs_halt",  1, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0));
    tbl_b.push_back(mk("run_after",    0, 1, 0, 0, 0, 0, 0, 0,  0,  1, 0, 0, 0));

    foreach (tbl_b[i]) step(tbl_b[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
